inst_fetch: RTL

Instruction-fetch stage of the pipelined CPU. It holds the program counter and drives the instruction memory's read address. It captures the combinational instruction read into the IF/ID pipeline register. Next-PC selection covers exception entry, branch/jump redirect, stall and sequential fetch, and the IF/ID register supports stall (hold) and flush (bubble) control from the hazard unit.

---
 rtl/inst_fetch.sv | 78 +++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register with stall (hold) and flush (bubble) control.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0180,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] InstAddr,
    input  logic [31:0] InstData,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        ExcReq,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;

    // Modulo-2^32 add: 32'hFFFF_FFFC wraps to 0 by design.
    assign pc_plus4 = pc + 32'd4;
    assign redirect = ExcReq | BranchTaken | JumpTaken;

    // A redirect always beats Stall so it is never lost; targets are word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        if (ExcReq)
            next_pc = {EXC_PC[31:2], 2'b00};
        else if (BranchTaken)
            next_pc = {BranchTarget[31:2], 2'b00};
        else if (JumpTaken)
            next_pc = {JumpTarget[31:2], 2'b00};
        else if (Stall)
            next_pc = pc;
    end

    // NOTE: reset sits in the sensitivity list so it acts without a clock edge;
    // all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= next_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_Inst    <= NOP_INST;
            IF_ID_PC      <= 32'd0;
            IF_ID_PCPlus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else if (Flush || redirect) begin
            IF_ID_Inst    <= NOP_INST;
            IF_ID_PC      <= 32'd0;
            IF_ID_PCPlus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else if (!Stall) begin
            IF_ID_Inst    <= InstData;
            IF_ID_PC      <= pc;
            IF_ID_PCPlus4 <= pc_plus4;
            IF_ID_Valid   <= 1'b1;
        end
    end

    // Register output only: no combinational path from any input to the memory address.
    assign InstAddr = pc;

endmodule
